// File: rtl/t07_wb_pkg.sv
// Shared Wishbone definitions: arbiter state encoding, arbitration modes
// and default bus widths used by the manager, arbiter and decoder.
package t07_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        ERR  = 2'd2
    } arbState_t;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/t07_rr_pick.sv
// Combinational winner picker: round-robin starting after `last`, or fixed
// priority with the lowest index winning. Outputs a one-hot winner and index.
module t07_rr_pick #(
    parameter int NUM_M = 2,
    parameter int IDX_W = 1
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] last,
    input  logic             mode,
    output logic [NUM_M-1:0] winOneHot,
    output logic [IDX_W-1:0] winIdx
);

    // candIdx[k] is the master examined at priority slot k (slot 0 is highest)
    logic [IDX_W-1:0] candIdx [NUM_M];
    logic             found;

    generate
        for (genvar gi = 0; gi < NUM_M; gi++) begin : gCand
            assign candIdx[gi] = mode ? IDX_W'(gi)
                                      : IDX_W'((int'(last) + gi + 1) % NUM_M);
        end
    endgenerate

    always_comb begin
        found     = 1'b0;
        winIdx    = '0;
        winOneHot = '0;
        for (int k = 0; k < NUM_M; k++) begin
            if (!found && req[candIdx[k]]) begin
                found  = 1'b1;
                winIdx = candIdx[k];
            end
        end
        if (found) begin
            winOneHot = NUM_M'(1) << winIdx;
        end
    end

endmodule

// File: rtl/t07_wb_rr_arbiter.sv
// N-master classic Wishbone arbiter with bus-cycle grant locking, per-transfer
// ack timeout returning a one-cycle error, and a one-hot grant status output.
module t07_wb_rr_arbiter
    import t07_wb_pkg::*;
#(
    parameter int NUM_M   = 2,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MODE    = MODE_RR,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       nrst,
    input  logic [NUM_M-1:0]           m_cyc_i,
    input  logic [NUM_M-1:0]           m_stb_i,
    input  logic [NUM_M-1:0]           m_we_i,
    input  logic [NUM_M*ADDR_W-1:0]    m_adr_i,
    input  logic [NUM_M*DATA_W-1:0]    m_dat_i,
    input  logic [NUM_M*DATA_W/8-1:0]  m_sel_i,
    output logic [NUM_M-1:0]           m_ack_o,
    output logic [NUM_M-1:0]           m_err_o,
    output logic [NUM_M*DATA_W-1:0]    m_dat_o,
    output logic                       s_cyc_o,
    output logic                       s_stb_o,
    output logic                       s_we_o,
    output logic [ADDR_W-1:0]          s_adr_o,
    output logic [DATA_W-1:0]          s_dat_o,
    output logic [DATA_W/8-1:0]        s_sel_o,
    input  logic                       s_ack_i,
    input  logic [DATA_W-1:0]          s_dat_i,
    output logic [NUM_M-1:0]           grant_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int IDX_W = $clog2(NUM_M);
    // A zero TIMEOUT still needs a legal one-bit counter; it is never compared.
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arbState_t        stateReg;
    logic [NUM_M-1:0] grantReg;
    logic [IDX_W-1:0] grantIdxReg;
    logic [IDX_W-1:0] lastReg;
    logic [CNT_W-1:0] cntReg;

    logic [NUM_M-1:0] pickOneHot;
    logic [IDX_W-1:0] pickIdx;

    t07_rr_pick #(
        .NUM_M (NUM_M),
        .IDX_W (IDX_W)
    ) uPick (
        .req       (m_cyc_i),
        .last      (lastReg),
        .mode      (MODE == MODE_FIXED),
        .winOneHot (pickOneHot),
        .winIdx    (pickIdx)
    );

    // Slave side follows the owner combinationally so a dropped cyc is seen at once.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        if (stateReg == OWN) begin
            s_cyc_o = m_cyc_i[grantIdxReg];
            s_stb_o = m_stb_i[grantIdxReg];
            s_we_o  = m_we_i[grantIdxReg];
            s_adr_o = m_adr_i[grantIdxReg*ADDR_W +: ADDR_W];
            s_dat_o = m_dat_i[grantIdxReg*DATA_W +: DATA_W];
            s_sel_o = m_sel_i[grantIdxReg*SEL_W +: SEL_W];
        end
    end

    assign m_ack_o = (stateReg == OWN && s_ack_i) ? grantReg : '0;
    assign m_err_o = (stateReg == ERR) ? grantReg : '0;
    assign m_dat_o = {NUM_M{s_dat_i}};
    assign grant_o = grantReg;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stateReg    <= IDLE;
            grantReg    <= '0;
            grantIdxReg <= '0;
            lastReg     <= IDX_W'(NUM_M - 1);
            cntReg      <= '0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (|m_cyc_i) begin
                        stateReg    <= OWN;
                        grantReg    <= pickOneHot;
                        grantIdxReg <= pickIdx;
                        lastReg     <= pickIdx;
                        cntReg      <= '0;
                    end
                end
                OWN: begin
                    if (!m_cyc_i[grantIdxReg]) begin
                        stateReg <= IDLE;
                        grantReg <= '0;
                        cntReg   <= '0;
                    end else if (s_ack_i) begin
                        // an ack on the final counted cycle still beats the timeout
                        cntReg <= '0;
                    end else if (s_stb_o) begin
                        if (TIMEOUT != 0 && cntReg == CNT_LAST) begin
                            stateReg <= ERR;
                            cntReg   <= '0;
                        end else begin
                            cntReg <= cntReg + 1'b1;
                        end
                    end
                end
                ERR: begin
                    stateReg <= IDLE;
                    grantReg <= '0;
                end
                default: begin
                    stateReg <= IDLE;
                    grantReg <= '0;
                end
            endcase
        end
    end

endmodule
